// File: rtl/r22sdf_ctrl.sv
// rtl/r22sdf_ctrl.sv - frame sequencer for a cascade of R2^2SDF FFT stages
// Gates the shared pipeline enable, tracks fill and tags cascade output samples.
module r22sdf_ctrl #(
   parameter int fft_length   = 64,
   parameter int pipe_latency = 0,
   localparam int idx_w   = $clog2(fft_length),
   localparam int n_stage = (idx_w + 1) / 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [n_stage-1:0] cordic_rdy,
   input  logic               in_valid,
   input  logic               in_sop,
   output logic               in_ready,
   input  logic               flush,
   output logic               sys_en,
   output logic               sys_en_glb,
   output logic               zero_ins,
   output logic               out_valid,
   output logic               out_sop,
   output logic               out_eop,
   output logic [idx_w-1:0]   out_idx,
   output logic               frame_err
);

   localparam int lat   = fft_length - 1 + pipe_latency;
   localparam int cnt_w = $clog2(lat + 1);
   localparam logic [cnt_w-1:0] lat_c    = cnt_w'(lat);
   localparam logic [cnt_w-1:0] lat_m1   = cnt_w'(lat - 1);
   localparam logic [idx_w-1:0] last_idx = idx_w'(fft_length - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [idx_w-1:0]   in_idx;
   logic [idx_w-1:0]   out_cnt;
   logic [cnt_w-1:0]   fill_cnt;
   logic [cnt_w-1:0]   flush_cnt;
   logic               flush_flag;

   logic all_rdy;
   logic drop;
   logic pending;
   logic run_open;
   logic take;
   logic produce;
   logic sop_err;
   logic flush_done;

   assign all_rdy    = &cordic_rdy;
   assign drop       = (state != S_INIT) && !all_rdy;
   assign pending    = flush_flag | flush;
   // At a frame boundary a pending flush closes the input before any new sample
   assign run_open   = !(pending && (in_idx == '0));
   assign take       = sys_en_glb & ~zero_ins;
   assign produce    = sys_en_glb & (fill_cnt == lat_c);
   assign sop_err    = (state == S_RUN) & take & in_sop & (in_idx != '0);
   assign flush_done = (state == S_FLUSH) && (flush_cnt == lat_m1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (drop) begin
         state_nxt = S_INIT;
      end else begin
         unique case (state)
            S_INIT:  if (all_rdy) state_nxt = S_IDLE;
            S_IDLE:  if (take) state_nxt = S_RUN;
            S_RUN:   if (!run_open) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_done) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
         endcase
      end
   end

   always_comb begin
      in_ready   = 1'b0;
      sys_en_glb = 1'b0;
      zero_ins   = 1'b0;
      if (!drop) begin
         unique case (state)
            S_IDLE: begin
               in_ready   = 1'b1;
               sys_en_glb = in_valid & in_sop;
            end
            S_RUN: begin
               in_ready   = run_open;
               sys_en_glb = in_valid & run_open;
            end
            S_FLUSH: begin
               sys_en_glb = 1'b1;
               zero_ins   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst || drop) begin
         in_idx     <= '0;
         out_cnt    <= '0;
         fill_cnt   <= '0;
         flush_cnt  <= '0;
         flush_flag <= 1'b0;
      end else begin
         if (take) in_idx <= in_idx + idx_w'(1);
         if (sys_en_glb && (fill_cnt != lat_c)) fill_cnt <= fill_cnt + cnt_w'(1);
         if (produce) out_cnt <= out_cnt + idx_w'(1);
         flush_cnt  <= (state == S_FLUSH) ? flush_cnt + cnt_w'(1) : '0;
         flush_flag <= pending;
         if ((state == S_IDLE) && !take && (fill_cnt == '0)) flush_flag <= 1'b0;
         if (flush_done) begin
            in_idx     <= '0;
            out_cnt    <= '0;
            fill_cnt   <= '0;
            flush_cnt  <= '0;
            flush_flag <= 1'b0;
         end
      end
   end

   // out_idx holds the index of the last tagged output between valid cycles
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sys_en    <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_idx   <= '0;
         frame_err <= 1'b0;
      end else begin
         sys_en    <= 1'b1;
         out_valid <= produce;
         out_sop   <= produce && (out_cnt == '0);
         out_eop   <= produce && (out_cnt == last_idx);
         frame_err <= drop | sop_err;
         if (produce) begin
            out_idx <= out_cnt;
         end else if (drop) begin
            out_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_r22sdf_ctrl.sv
// tb/tb_r22sdf_ctrl.sv - self-checking bench for r22sdf_ctrl (N=16, pipe_latency=2)
module tb_r22sdf_ctrl;

   localparam int N  = 16;
   localparam int PL = 2;
   localparam int L  = N - 1 + PL;
   localparam int IW = 4;
   localparam int NS = 2;
   localparam int M_INIT = 0, M_IDLE = 1, M_RUN = 2, M_FLUSH = 3;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [NS-1:0] cordic_rdy = '0;
   logic          in_valid = 1'b0;
   logic          in_sop = 1'b0;
   logic          flush = 1'b0;
   logic          in_ready, sys_en, sys_en_glb, zero_ins;
   logic          out_valid, out_sop, out_eop, frame_err;
   logic [IW-1:0] out_idx;

   r22sdf_ctrl #(.fft_length(N), .pipe_latency(PL)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cordic_rdy(cordic_rdy),
      .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready), .flush(flush),
      .sys_en(sys_en), .sys_en_glb(sys_en_glb), .zero_ins(zero_ins),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_idx(out_idx), .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference: mode, samples taken this run, total enabled cycles, flush cycles left
   int m_mode, m_in, m_en, m_left;
   bit m_pend;
   bit exp_ready, exp_glb, exp_zero, exp_sys_en, exp_valid, exp_sop, exp_eop, exp_err;
   int exp_idx;
   logic [7:0] act_vec, exp_vec;

   task automatic do_reset();
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      m_mode = M_INIT; m_in = 0; m_en = 0; m_left = 0; m_pend = 0;
      exp_idx = 0; exp_sys_en = 0;
   endtask

   // Advances one clock; output index is the count of outputs so far modulo N
   task automatic step();
      bit rdy, drop, pend, take;
      int idx;
      rdy  = &cordic_rdy;
      drop = (m_mode != M_INIT) && !rdy;
      pend = m_pend || flush;
      idx  = m_in % N;
      exp_ready = !drop && (m_mode == M_IDLE || (m_mode == M_RUN && !(pend && idx == 0)));
      take      = exp_ready && in_valid && (m_mode == M_RUN || in_sop);
      exp_zero  = !drop && m_mode == M_FLUSH;
      exp_glb   = take || exp_zero;
      exp_valid = exp_glb && m_en >= L;
      if (exp_valid) exp_idx = (m_en - L) % N;
      exp_sop = exp_valid && exp_idx == 0;
      exp_eop = exp_valid && exp_idx == N - 1;
      exp_err = drop || (m_mode == M_RUN && take && in_sop && idx != 0);
      #3;
      act_vec[7:5] = {in_ready, sys_en_glb, zero_ins};
      @(posedge sys_clk); #1;
      cyc++;
      if (drop) begin
         m_mode = M_INIT; m_in = 0; m_en = 0; m_left = 0; m_pend = 0;
      end else begin
         case (m_mode)
            M_INIT: begin
               m_pend = pend;
               if (rdy) m_mode = M_IDLE;
            end
            M_IDLE: begin
               if (take) begin
                  m_mode = M_RUN; m_in = 1; m_en++; m_pend = pend;
               end else begin
                  m_pend = 0;
               end
            end
            M_RUN: begin
               m_pend = pend;
               if (take) begin
                  m_in++; m_en++;
               end else if (pend && idx == 0) begin
                  m_mode = M_FLUSH; m_left = L;
               end
            end
            default: begin
               m_en++; m_left--; m_pend = pend;
               if (m_left == 0) begin
                  m_mode = M_IDLE; m_in = 0; m_en = 0; m_pend = 0;
               end
            end
         endcase
      end
      exp_sys_en = 1;
      act_vec[4:0] = {sys_en, out_valid, out_sop, out_eop, frame_err};
      exp_vec = {exp_ready, exp_glb, exp_zero, exp_sys_en, exp_valid, exp_sop, exp_eop, exp_err};
   endtask

   task automatic test_reset();
      cordic_rdy = '0;
      do_reset();
      total++;
      if ({in_ready, sys_en, sys_en_glb, zero_ins, out_valid, out_sop, out_eop, frame_err, out_idx} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%b want=0", {in_ready, sys_en, sys_en_glb, zero_ins, out_valid, out_sop, out_eop, frame_err, out_idx});
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 4) cordic_rdy = '1;
         step();
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL init_wait cyc=%0d got=%b want=%b", cyc, act_vec, exp_vec);
         end
      end
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_entry in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_single_frame();
      int n_out = 0, n_zero = 0;
      for (int i = 0; i < N + 1 + 25; i++) begin
         in_valid = (i < N);
         in_sop   = (i == 0);
         flush    = (i == N);
         step();
         n_out  += int'(out_valid);
         n_zero += int'(act_vec[5]);
         total++;
         if (act_vec !== exp_vec || (exp_valid && out_idx !== exp_idx[IW-1:0])) begin
            bad++;
            $display("FAIL single_frame cyc=%0d got=%b idx=%0d want=%b idx=%0d", cyc, act_vec, out_idx, exp_vec, exp_idx);
         end
      end
      flush = 1'b0;
      total++;
      if (n_out !== N || n_zero !== L || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_counts outputs=%0d flush_cycles=%0d ready=%b want %0d/%0d/1", n_out, n_zero, in_ready, N, L);
      end
   endtask

   task automatic test_gaps();
      int acc = 0, n_out = 0, n_sop = 0, guard = 0;
      while (acc < 2 * N && guard < 400) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_sop   = in_valid && (acc % N == 0);
         step();
         guard++;
         if (in_valid && exp_ready) acc++;
         n_out += int'(out_valid);
         n_sop += int'(out_sop);
         total++;
         if (act_vec !== exp_vec || (exp_valid && out_idx !== exp_idx[IW-1:0])) begin
            bad++;
            $display("FAIL gaps cyc=%0d got=%b idx=%0d want=%b idx=%0d", cyc, act_vec, out_idx, exp_vec, exp_idx);
         end
      end
      in_valid = 1'b0; in_sop = 1'b0;
      for (int i = 0; i < 26; i++) begin
         flush = (i == 0);
         step();
         n_out += int'(out_valid);
         n_sop += int'(out_sop);
         total++;
         if (act_vec !== exp_vec || (exp_valid && out_idx !== exp_idx[IW-1:0])) begin
            bad++;
            $display("FAIL gaps_drain cyc=%0d got=%b idx=%0d want=%b idx=%0d", cyc, act_vec, out_idx, exp_vec, exp_idx);
         end
      end
      flush = 1'b0;
      total++;
      if (n_out !== 2 * N || n_sop !== 2 || guard >= 400) begin
         bad++;
         $display("FAIL gaps_counts outputs=%0d sops=%0d guard=%0d want %0d/2", n_out, n_sop, guard, 2 * N);
      end
   endtask

   task automatic test_flush_mid();
      int acc = 0, after = 0, guard = 0;
      bit flushed = 0;
      while (!act_vec[5] && guard < 60) begin
         in_valid = 1'b1;
         in_sop   = (acc % N == 0);
         flush    = (acc == 7);
         if (acc == 7) flushed = 1;
         step();
         guard++;
         if (in_valid && act_vec[7]) begin
            acc++;
            if (flushed) after++;
         end
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL flush_mid cyc=%0d got=%b want=%b", cyc, act_vec, exp_vec);
         end
      end
      flush = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
      total++;
      if (after !== 9) begin
         bad++;
         $display("FAIL flush_mid_count accepted_after_flush=%0d want 9", after);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if (act_vec !== exp_vec || (exp_valid && out_idx !== exp_idx[IW-1:0])) begin
            bad++;
            $display("FAIL flush_mid_drain cyc=%0d got=%b idx=%0d want=%b idx=%0d", cyc, act_vec, out_idx, exp_vec, exp_idx);
         end
      end
   endtask

   task automatic test_sop_err();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sop = 1'b0;
         step();
         total++;
         if (act_vec[6] !== 1'b0 || act_vec !== exp_vec) begin
            bad++;
            $display("FAIL idle_nosop cyc=%0d got=%b want=%b", cyc, act_vec, exp_vec);
         end
      end
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_sop   = (i == 0 || i == 3);
         step();
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL sop_err cyc=%0d got=%b want=%b", cyc, act_vec, exp_vec);
         end
         if (i == 3 || i == 4) begin
            total++;
            if (frame_err !== (i == 3)) begin
               bad++;
               $display("FAIL sop_err_pulse step=%0d frame_err=%b want %0d", i, frame_err, (i == 3));
            end
         end
      end
      in_sop = 1'b0;
   endtask

   task automatic test_cordic_drop();
      for (int i = 0; i < 4; i++) begin
         cordic_rdy = (i == 1) ? 2'b01 : 2'b11;
         step();
         total++;
         if (act_vec !== exp_vec) begin
            bad++;
            $display("FAIL cordic_drop cyc=%0d got=%b want=%b", cyc, act_vec, exp_vec);
         end
         if (i == 1) begin
            total++;
            if (frame_err !== 1'b1 || in_ready !== 1'b0) begin
               bad++;
               $display("FAIL drop_to_init frame_err=%b in_ready=%b want 1/0", frame_err, in_ready);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_flush();
      for (int i = 0; i < N + 6; i++) begin
         in_valid = (i < N);
         in_sop   = (i == 0);
         flush    = (i == N);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
      total++;
      if (zero_ins !== 1'b1) begin
         bad++;
         $display("FAIL in_flush zero_ins=%b want 1", zero_ins);
      end
      do_reset();
      total++;
      if ({in_ready, sys_en, sys_en_glb, zero_ins, out_valid, out_sop, out_eop, frame_err, out_idx} !== '0) begin
         bad++;
         $display("FAIL reset_mid_flush got=%b want=0", {in_ready, sys_en, sys_en_glb, zero_ins, out_valid, out_sop, out_eop, frame_err, out_idx});
      end
      step();
   endtask

   task automatic test_random_soak();
      for (int i = 0; i < 600; i++) begin
         in_valid   = ($urandom_range(0, 9) < 7);
         in_sop     = ($urandom_range(0, 9) == 0) || (m_in % N == 0);
         flush      = ($urandom_range(0, 39) == 0);
         cordic_rdy = ($urandom_range(0, 199) == 0) ? 2'(($urandom_range(0, 2))) : 2'b11;
         step();
         total++;
         if (act_vec !== exp_vec || (exp_valid && out_idx !== exp_idx[IW-1:0])) begin
            bad++;
            $display("FAIL soak cyc=%0d got=%b idx=%0d want=%b idx=%0d", cyc, act_vec, out_idx, exp_vec, exp_idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gaps();
      test_flush_mid();
      test_sop_err();
      test_cordic_drop();
      test_reset_mid_flush();
      test_random_soak();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
